hpdcache_amo_seq: RTL and testbench

//  Sequencer for uncached read-modify-write atomics (AMOSWAP/ADD/AND/OR/XOR/MAX/MAXU/MIN/MINU).

---
 rtl/hpdcache_amo_seq.sv | 167 ++++++++++++++++
 tb/tb_hpdcache_amo_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_amo_seq.sv
// Uncached AMO sequencer: read old value, feed the external AMO ALU, write the
// result back, then return the old value. One AMO in flight at a time.
module hpdcache_amo_seq #(
  parameter int unsigned PA_WIDTH  = 56,
  parameter int unsigned TID_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [12:0]          req_op_i,
  input  logic [PA_WIDTH-1:0]  req_addr_i,
  input  logic [1:0]           req_size_i,
  input  logic [63:0]          req_data_i,
  input  logic [TID_WIDTH-1:0] req_tid_i,

  output logic                 mem_rd_valid_o,
  input  logic                 mem_rd_ready_i,
  output logic [PA_WIDTH-1:0]  mem_rd_addr_o,
  input  logic                 mem_rd_rsp_valid_i,
  input  logic [63:0]          mem_rd_rsp_data_i,
  input  logic                 mem_rd_rsp_error_i,

  output logic                 mem_wr_valid_o,
  input  logic                 mem_wr_ready_i,
  output logic [PA_WIDTH-1:0]  mem_wr_addr_o,
  output logic [63:0]          mem_wr_data_o,
  output logic [7:0]           mem_wr_be_o,
  input  logic                 mem_wr_rsp_valid_i,
  input  logic                 mem_wr_rsp_error_i,

  output logic [12:0]          amo_op_o,
  output logic [63:0]          amo_ld_data_o,
  output logic [63:0]          amo_st_data_o,
  input  logic [63:0]          amo_result_i,

  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [63:0]          rsp_data_o,
  output logic                 rsp_error_o,
  output logic [TID_WIDTH-1:0] rsp_tid_o
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RSP
  } state_e;

  state_e               state_q, state_d;
  logic [12:0]          op_q, op_d;
  logic [PA_WIDTH-1:0]  addr_q, addr_d;
  logic                 word_q, word_d;
  logic [63:0]          data_q, data_d;
  logic [TID_WIDTH-1:0] tid_q, tid_d;
  logic [63:0]          old_q, old_d;
  logic [63:0]          result_q, result_d;
  logic                 err_q, err_d;

  logic                 op_bad, size_bad, align_bad, req_illegal;
  logic [31:0]          rd_lane;
  logic [63:0]          rd_old;
  logic [PA_WIDTH-1:0]  addr_aligned;

  // Exactly one of bits 8..0 may be set; anything in 12..9 is a non-AMO uc op.
  assign op_bad      = (req_op_i[12:9] != 4'd0) || (req_op_i[8:0] == 9'd0) ||
                       ((req_op_i & (req_op_i - 13'd1)) != 13'd0);
  assign size_bad    = ~req_size_i[1];
  assign align_bad   = req_size_i[0] ? (req_addr_i[2:0] != 3'd0) : (req_addr_i[1:0] != 2'd0);
  assign req_illegal = op_bad | size_bad | align_bad;

  assign rd_lane = addr_q[2] ? mem_rd_rsp_data_i[63:32] : mem_rd_rsp_data_i[31:0];
  assign rd_old  = word_q ? {{32{rd_lane[31]}}, rd_lane} : mem_rd_rsp_data_i;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    word_d   = word_q;
    data_d   = data_q;
    tid_d    = tid_q;
    old_d    = old_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          addr_d  = req_addr_i;
          word_d  = (req_size_i == 2'd2);
          data_d  = req_data_i;
          tid_d   = req_tid_i;
          old_d   = 64'd0;
          err_d   = req_illegal;
          state_d = req_illegal ? RSP : RD_REQ;
        end
      end
      RD_REQ:  if (mem_rd_ready_i) state_d = RD_WAIT;
      RD_WAIT: begin
        if (mem_rd_rsp_valid_i) begin
          if (mem_rd_rsp_error_i) begin
            err_d   = 1'b1;
            old_d   = 64'd0;
            state_d = RSP;
          end else begin
            // ALU sees rd_old combinationally this cycle, so its result is valid here.
            old_d    = rd_old;
            result_d = amo_result_i;
            state_d  = WR_REQ;
          end
        end
      end
      WR_REQ:  if (mem_wr_ready_i) state_d = WR_WAIT;
      WR_WAIT: begin
        if (mem_wr_rsp_valid_i) begin
          err_d   = err_q | mem_wr_rsp_error_i;
          state_d = RSP;
        end
      end
      RSP:     if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= 13'd0;
      addr_q   <= '0;
      word_q   <= 1'b0;
      data_q   <= 64'd0;
      tid_q    <= '0;
      old_q    <= 64'd0;
      result_q <= 64'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      word_q   <= word_d;
      data_q   <= data_d;
      tid_q    <= tid_d;
      old_q    <= old_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign addr_aligned = {addr_q[PA_WIDTH-1:3], 3'b000};

  assign req_ready_o    = (state_q == IDLE);
  assign mem_rd_valid_o = (state_q == RD_REQ);
  assign mem_rd_addr_o  = addr_aligned;
  assign mem_wr_valid_o = (state_q == WR_REQ);
  assign mem_wr_addr_o  = addr_aligned;
  assign mem_wr_data_o  = word_q ? {2{result_q[31:0]}} : result_q;
  assign mem_wr_be_o    = word_q ? (addr_q[2] ? 8'hF0 : 8'h0F) : 8'hFF;

  assign amo_op_o      = op_q;
  assign amo_ld_data_o = (state_q == RD_WAIT) ? rd_old : old_q;
  assign amo_st_data_o = word_q ? {{32{data_q[31]}}, data_q[31:0]} : data_q;

  assign rsp_valid_o = (state_q == RSP);
  assign rsp_data_o  = old_q;
  assign rsp_error_o = err_q;
  assign rsp_tid_o   = tid_q;

endmodule

// File: tb/tb_hpdcache_amo_seq.sv
// Directed bench for hpdcache_amo_seq: vector table plus backpressure and reset-abort sequences.
module tb_hpdcache_amo_seq;

  localparam logic [12:0] OP_SWAP = 13'h100, OP_ADD = 13'h080, OP_AND = 13'h040,
                          OP_OR   = 13'h020, OP_XOR = 13'h010, OP_MAX = 13'h008,
                          OP_MAXU = 13'h004, OP_MIN = 13'h002, OP_MINU = 13'h001;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [12:0] req_op;
  logic [55:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_data;
  logic [3:0]  req_tid;
  logic        rd_valid, rd_ready, rd_rsp_valid, rd_rsp_error;
  logic [55:0] rd_addr;
  logic [63:0] rd_rsp_data;
  logic        wr_valid, wr_ready, wr_rsp_valid, wr_rsp_error;
  logic [55:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic [12:0] amo_op;
  logic [63:0] amo_ld, amo_st, amo_res;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_tid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hpdcache_amo_seq #(.PA_WIDTH(56), .TID_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_data_i(req_data), .req_tid_i(req_tid),
    .mem_rd_valid_o(rd_valid), .mem_rd_ready_i(rd_ready), .mem_rd_addr_o(rd_addr),
    .mem_rd_rsp_valid_i(rd_rsp_valid), .mem_rd_rsp_data_i(rd_rsp_data),
    .mem_rd_rsp_error_i(rd_rsp_error),
    .mem_wr_valid_o(wr_valid), .mem_wr_ready_i(wr_ready), .mem_wr_addr_o(wr_addr),
    .mem_wr_data_o(wr_data), .mem_wr_be_o(wr_be),
    .mem_wr_rsp_valid_i(wr_rsp_valid), .mem_wr_rsp_error_i(wr_rsp_error),
    .amo_op_o(amo_op), .amo_ld_data_o(amo_ld), .amo_st_data_o(amo_st), .amo_result_i(amo_res),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_error_o(rsp_error), .rsp_tid_o(rsp_tid)
  );

  // Reference AMO ALU on 64-bit (already sign-extended for words) operands.
  always_comb begin
    amo_res = 64'd0;
    case (amo_op)
      OP_SWAP: amo_res = amo_st;
      OP_ADD:  amo_res = amo_ld + amo_st;
      OP_AND:  amo_res = amo_ld & amo_st;
      OP_OR:   amo_res = amo_ld | amo_st;
      OP_XOR:  amo_res = amo_ld ^ amo_st;
      OP_MAX:  amo_res = ($signed(amo_ld) > $signed(amo_st)) ? amo_ld : amo_st;
      OP_MAXU: amo_res = (amo_ld > amo_st) ? amo_ld : amo_st;
      OP_MIN:  amo_res = ($signed(amo_ld) < $signed(amo_st)) ? amo_ld : amo_st;
      OP_MINU: amo_res = (amo_ld < amo_st) ? amo_ld : amo_st;
      default: amo_res = 64'd0;
    endcase
  end

  typedef struct {
    string       name;
    logic [12:0] op;
    logic [55:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
    logic [63:0] mem;
    logic        rd_err;
    logic        wr_err;
    logic [3:0]  tid;
    logic        exp_rd;
    logic        exp_wr;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_be;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 0; rd_ready = 0; wr_ready = 0; rsp_ready = 0;
    rd_rsp_valid = 0; rd_rsp_error = 0; rd_rsp_data = 64'd0;
    wr_rsp_valid = 0; wr_rsp_error = 0;
  endtask

  // Drives one request and services the memory side; stall cycles of ready=0
  // are inserted before each valid is accepted, checking payload stability.
  task automatic run_amo(input vec_t v, input int stall);
    int n, rd_cnt, wr_cnt, lat, rd_st, wr_st, rs_st;
    logic done, rd_pend, wr_pend, rd_seen, wr_seen, rs_seen, stable;
    logic [55:0] rd_a, wr_a;
    logic [63:0] wr_d, rs_d;
    logic [7:0]  wr_b;
    logic        rs_e;
    logic [3:0]  rs_t;
    n = 0; rd_cnt = 0; wr_cnt = 0; lat = 0; rd_st = 0; wr_st = 0; rs_st = 0;
    done = 0; rd_pend = 0; wr_pend = 0; rd_seen = 0; wr_seen = 0; rs_seen = 0; stable = 1;
    rd_a = '0; wr_a = '0; wr_d = '0; rs_d = '0; wr_b = '0; rs_e = 0; rs_t = '0;
    @(negedge clk);
    chk({v.name, ".req_ready"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1; req_op = v.op; req_addr = v.addr; req_size = v.size;
    req_data = v.data; req_tid = v.tid;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
      idle_inputs();
      if (rd_pend) begin
        rd_rsp_valid = 1; rd_rsp_data = v.mem; rd_rsp_error = v.rd_err; rd_pend = 0;
      end
      if (wr_pend) begin
        wr_rsp_valid = 1; wr_rsp_error = v.wr_err; wr_pend = 0;
      end
      if (rd_valid) begin
        if (!rd_seen) begin rd_seen = 1; rd_a = rd_addr; end
        else if (rd_addr !== rd_a) stable = 0;
        if (rd_st < stall) rd_st++;
        else begin rd_ready = 1; rd_cnt++; rd_pend = 1; rd_seen = 0; end
      end
      if (wr_valid) begin
        if (!wr_seen) begin wr_seen = 1; wr_a = wr_addr; wr_d = wr_data; wr_b = wr_be; end
        else if (wr_addr !== wr_a || wr_data !== wr_d || wr_be !== wr_b) stable = 0;
        if (wr_st < stall) wr_st++;
        else begin wr_ready = 1; wr_cnt++; wr_pend = 1; wr_seen = 0; end
      end
      if (rsp_valid) begin
        if (!rs_seen) begin
          rs_seen = 1; lat = n; rs_d = rsp_data; rs_e = rsp_error; rs_t = rsp_tid;
        end else if (rsp_data !== rs_d || rsp_error !== rs_e || rsp_tid !== rs_t) stable = 0;
        if (rs_st < stall) rs_st++;
        else begin rsp_ready = 1; done = 1; end
      end
    end
    @(negedge clk);
    idle_inputs();
    chk({v.name, ".completed"}, {63'd0, done}, 64'd1);
    chk({v.name, ".rsp_data"}, rs_d, v.exp_rdata);
    chk({v.name, ".rsp_error"}, {63'd0, rs_e}, {63'd0, v.exp_err});
    chk({v.name, ".rsp_tid"}, {60'd0, rs_t}, {60'd0, v.tid});
    chk({v.name, ".reads"}, 64'(rd_cnt), {63'd0, v.exp_rd});
    chk({v.name, ".writes"}, 64'(wr_cnt), {63'd0, v.exp_wr});
    if (v.exp_rd) chk({v.name, ".rd_addr"}, {8'd0, rd_a}, {8'd0, v.addr[55:3], 3'b000});
    if (v.exp_wr) begin
      chk({v.name, ".wr_addr"}, {8'd0, wr_a}, {8'd0, v.addr[55:3], 3'b000});
      chk({v.name, ".wr_data"}, wr_d, v.exp_wdata);
      chk({v.name, ".wr_be"}, {56'd0, wr_b}, {56'd0, v.exp_be});
    end
    if (!v.exp_rd) chk({v.name, ".illegal_latency"}, 64'(lat), 64'd1);
    if (stall > 0) chk({v.name, ".stable_under_stall"}, {63'd0, stable}, 64'd1);
    chk({v.name, ".back_to_idle"}, {63'd0, req_ready}, 64'd1);
  endtask

  vec_t vecs[9];

  initial begin
    int k;
    logic ok;
    idle_inputs();
    req_op = 13'd0; req_addr = '0; req_size = 2'd0; req_data = 64'd0; req_tid = 4'd0;
    rst = 1;

    //          name          op       addr        sz  data                   mem                    rde wre tid rd wr exp_wdata              be     exp_rdata              err
    vecs[0] = '{"add_d",      OP_ADD,  56'h1000,  3, 64'h5,                 64'h10,                0, 0, 1, 1, 1, 64'h15,                8'hFF, 64'h10,                0};
    vecs[1] = '{"min_w_hi",   OP_MIN,  56'h1004,  2, 64'h3,                 64'hFFFFFFFF_00000007, 0, 0, 2, 1, 1, 64'hFFFFFFFF_FFFFFFFF, 8'hF0, 64'hFFFFFFFF_FFFFFFFF, 0};
    vecs[2] = '{"maxu_w_lo",  OP_MAXU, 56'h1000,  2, 64'h7FFFFFFF,          64'h12345678_80000000, 0, 0, 3, 1, 1, 64'h80000000_80000000, 8'h0F, 64'hFFFFFFFF_80000000, 0};
    vecs[3] = '{"swap_rderr", OP_SWAP, 56'h2000,  3, 64'hDEAD,              64'h1234,              1, 0, 4, 1, 0, 64'h0,                 8'h00, 64'h0,                 1};
    vecs[4] = '{"ill_size1",  OP_ADD,  56'h1000,  1, 64'h1,                 64'h0,                 0, 0, 5, 0, 0, 64'h0,                 8'h00, 64'h0,                 1};
    vecs[5] = '{"ill_op10",   13'h400, 56'h1000,  3, 64'h1,                 64'h0,                 0, 0, 6, 0, 0, 64'h0,                 8'h00, 64'h0,                 1};
    vecs[6] = '{"ill_align",  OP_ADD,  56'h1004,  3, 64'h1,                 64'h0,                 0, 0, 7, 0, 0, 64'h0,                 8'h00, 64'h0,                 1};
    vecs[7] = '{"xor_wrerr",  OP_XOR,  56'h3008,  3, 64'hFF00,              64'h0F0F,              0, 1, 8, 1, 1, 64'hF00F,              8'hFF, 64'h0F0F,              1};
    vecs[8] = '{"and_w_lo",   OP_AND,  56'h1008,  2, 64'hFF00FF00,          64'hAAAA0000_F0F0F0F0, 0, 0, 9, 1, 1, 64'hF000F000_F000F000, 8'h0F, 64'hFFFFFFFF_F0F0F0F0, 0};

    repeat (3) @(negedge clk);
    chk("reset.req_ready", {63'd0, req_ready}, 64'd1);
    chk("reset.valids", {61'd0, rd_valid, wr_valid, rsp_valid}, 64'd0);
    chk("reset.rsp_data", rsp_data, 64'd0);
    chk("reset.rsp_err_tid", {59'd0, rsp_error, rsp_tid}, 64'd0);
    rst = 0;

    for (int i = 0; i < 9; i++) run_amo(vecs[i], 0);

    // Two one-hot bits set in the AMO field is also illegal.
    run_amo('{"ill_twohot", OP_ADD | OP_OR, 56'h1000, 3, 64'h1, 64'h0, 0, 0, 10,
              0, 0, 64'h0, 8'h00, 64'h0, 1}, 0);

    // Backpressure on every handshake.
    run_amo('{"add_stall", OP_ADD, 56'h4000, 3, 64'h5, 64'h10, 0, 0, 11,
              1, 1, 64'h15, 8'hFF, 64'h10, 0}, 5);

    // Reset while waiting for the write ack; the late ack must be ignored.
    @(negedge clk);
    req_valid = 1; req_op = OP_ADD; req_addr = 56'h5000; req_size = 2'd3;
    req_data = 64'h1; req_tid = 4'd12;
    k = 0;
    while (!wr_valid && k < 20) begin
      @(negedge clk);
      k++;
      idle_inputs();
      if (rd_valid) rd_ready = 1;
      else if (!rd_rsp_valid && k == 2) begin rd_rsp_valid = 1; rd_rsp_data = 64'h7; end
    end
    chk("rstmid.reached_wr", {63'd0, wr_valid}, 64'd1);
    idle_inputs();
    wr_ready = 1;
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
    wr_rsp_valid = 1; wr_rsp_error = 1;
    ok = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle_inputs();
      if (rsp_valid || wr_valid || rd_valid || !req_ready || rsp_error) ok = 0;
    end
    chk("rstmid.idle_quiet", {63'd0, ok}, 64'd1);
    run_amo(vecs[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
